// File: rtl/sha_job_sequencer.sv
// sha_job_sequencer: drives the SHA-256 round core for a nonce sweep.
// Per nonce it streams an 80-byte header through three passes: block 0,
// block 1 with nonce and padding, and the second-hash pass. It then compares
// the core result against the target and reports the first winning nonce.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, stop              job launch pulse (ignored while busy), abort
//   header_in[607:0]         header bytes 0..75, word 0 in [607:576]
//   target, nonce_start/end  compare threshold and inclusive nonce range
//   hash_out[255:0]          core result
//   block, select, msg_in, K pass index, round index, message word, round constant
//   nonce_sig                one-cycle pulse on the first cycle of each nonce
//   busy, found, done        job running, golden nonce valid, job-end pulse
//   golden_nonce, nonce_cur  winning nonce, nonce under test
//
// Optional macro HASH_CMP_SWAP_EN: compare byte-reversed hash_out against target.
module sha_job_sequencer #(
    parameter int unsigned ROUNDS  = 64,
    parameter int unsigned ADD_CYC = 1,
    parameter int unsigned SETTLE  = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         stop,
    input  logic [607:0] header_in,
    input  logic [255:0] target,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
    input  logic [255:0] hash_out,
    output logic [1:0]   block,
    output logic [6:0]   select,
    output logic [31:0]  msg_in,
    output logic [31:0]  K,
    output logic         nonce_sig,
    output logic         busy,
    output logic         found,
    output logic         done,
    output logic [31:0]  golden_nonce,
    output logic [31:0]  nonce_cur
);

    localparam int unsigned PASS_LEN  = ROUNDS + ADD_CYC;
    localparam int unsigned HDR_WORDS = 19;

    localparam logic [31:0] K_TAB [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [2:0] {S_IDLE, S_B0, S_B1, S_B2, S_CHECK} state_t;

    state_t         state_q, state_n;
    logic [6:0]     cnt_q, cnt_n;
    logic [607:0]   hdr_q, hdr_n;
    logic [255:0]   tgt_q, tgt_n;
    logic [31:0]    end_q, end_n;
    logic [31:0]    nonce_n, golden_n, msg_n, k_n;
    logic [1:0]     block_n;
    logic [6:0]     select_n;
    logic           found_n, done_n, sig_n, busy_n;
    logic [255:0]   cmp_val;
    logic           hit;

    // Header word idx (0 = most significant 32 bits)
    function automatic logic [31:0] hdr_word(input logic [607:0] h, input logic [4:0] idx);
        logic [9:0] lsb;
        lsb = 10'(5'(HDR_WORDS - 1) - idx) * 10'd32;
        return h[lsb +: 32];
    endfunction

    // Target comparison value, optionally byte-reversed
    always_comb begin
        cmp_val = hash_out;
`ifdef HASH_CMP_SWAP_EN
        for (int i = 0; i < 32; i++) begin
            cmp_val[8*i +: 8] = hash_out[8*(31-i) +: 8];
        end
`endif
        hit = (cmp_val <= tgt_q);
    end

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            hdr_q        <= '0;
            tgt_q        <= '0;
            end_q        <= '0;
            block        <= '0;
            select       <= '0;
            msg_in       <= '0;
            K            <= '0;
            nonce_sig    <= 1'b0;
            busy         <= 1'b0;
            found        <= 1'b0;
            done         <= 1'b0;
            golden_nonce <= '0;
            nonce_cur    <= '0;
        end else begin
            state_q      <= state_n;
            cnt_q        <= cnt_n;
            hdr_q        <= hdr_n;
            tgt_q        <= tgt_n;
            end_q        <= end_n;
            block        <= block_n;
            select       <= select_n;
            msg_in       <= msg_n;
            K            <= k_n;
            nonce_sig    <= sig_n;
            busy         <= busy_n;
            found        <= found_n;
            done         <= done_n;
            golden_nonce <= golden_n;
            nonce_cur    <= nonce_n;
        end
    end

    // Next state, then the core-facing outputs for that next state
    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        hdr_n    = hdr_q;
        tgt_n    = tgt_q;
        end_n    = end_q;
        nonce_n  = nonce_cur;
        golden_n = golden_nonce;
        found_n  = found;
        done_n   = 1'b0;
        block_n  = '0;
        select_n = '0;
        msg_n    = '0;
        k_n      = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_n = S_B0;
                    cnt_n   = '0;
                    hdr_n   = header_in;
                    tgt_n   = target;
                    end_n   = nonce_end;
                    nonce_n = nonce_start;
                    found_n = 1'b0;
                end
            end
            S_B0, S_B1, S_B2: begin
                if (stop) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                    done_n  = 1'b1;
                end else if (cnt_q == 7'(PASS_LEN - 1)) begin
                    cnt_n   = '0;
                    state_n = (state_q == S_B0) ? S_B1 : (state_q == S_B1) ? S_B2 : S_CHECK;
                end else begin
                    cnt_n = cnt_q + 7'd1;
                end
            end
            S_CHECK: begin
                if (stop) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                    done_n  = 1'b1;
                end else if (cnt_q == 7'(SETTLE - 1)) begin
                    cnt_n = '0;
                    // A hit on the last nonce still reports found
                    if (hit) begin
                        golden_n = nonce_cur;
                        found_n  = 1'b1;
                        done_n   = 1'b1;
                        state_n  = S_IDLE;
                    end else if (nonce_cur == end_q) begin
                        done_n  = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        nonce_n = nonce_cur + 32'd1;
                        state_n = S_B0;
                    end
                end else begin
                    cnt_n = cnt_q + 7'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase

        case (state_n)
            S_B0: begin
                block_n = 2'd0;
                if (cnt_n < 7'd16) msg_n = hdr_word(hdr_n, cnt_n[4:0]);
            end
            S_B1: begin
                block_n = 2'd1;
                case (cnt_n)
                    7'd0, 7'd1, 7'd2: msg_n = hdr_word(hdr_n, 5'(cnt_n) + 5'd16);
                    7'd3:             msg_n = nonce_n;
                    7'd4:             msg_n = 32'h8000_0000;
                    7'd15:            msg_n = 32'h0000_0280;
                    default:          msg_n = '0;
                endcase
            end
            S_B2:    block_n = 2'd2;
            default: block_n = 2'd0;
        endcase

        if (state_n == S_B0 || state_n == S_B1 || state_n == S_B2) begin
            select_n = cnt_n;
            if (cnt_n < 7'd64) k_n = K_TAB[cnt_n[5:0]];
        end

        sig_n  = (state_n == S_B0) && (cnt_n == 7'd0);
        busy_n = (state_n != S_IDLE);
    end

endmodule
